// File: rtl/mantle_frame_collector.sv
// Deserialises a valid/ready word stream into a DEPTH-element frame, double-buffered.
// Optional MANTLE_FRAME_LAST_CHECK_EN adds I_last framing and a sticky err flag.
module mantle_frame_collector #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 9
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_valid,
    output logic             I_ready,
`ifdef MANTLE_FRAME_LAST_CHECK_EN
    input  logic             I_last,
    output logic             err,
`endif
    output logic [WIDTH-1:0] O [DEPTH-1:0],
    output logic             O_valid,
    input  logic             O_ready,
    output logic [15:0]      frame_count
);

    localparam int unsigned   IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_fill [DEPTH-1:0];
    logic [WIDTH-1:0] r_out  [DEPTH-1:0];
    logic             r_ovalid;
    logic             r_pending;
    logic [15:0]      r_count;
`ifdef MANTLE_FRAME_LAST_CHECK_EN
    logic             r_err;
`endif

    logic             w_accept;
    logic             w_at_last;
    logic             w_complete;
    logic             w_out_free;
    logic             w_handoff;
    logic [WIDTH-1:0] w_fill_nxt [DEPTH-1:0];

    assign I_ready    = !r_pending;
    assign w_accept   = I_valid && !r_pending;
    assign w_at_last  = (r_idx == LAST);
    assign w_handoff  = r_ovalid && O_ready;
    assign w_out_free = !r_ovalid || O_ready;
`ifdef MANTLE_FRAME_LAST_CHECK_EN
    assign w_complete = w_accept && (w_at_last || I_last);
`else
    assign w_complete = w_accept && w_at_last;
`endif

    // Fill buffer as it will look after this edge; the output register can load it directly.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_fill_nxt[k] = r_fill[k];
            if (w_accept && (IW'(k) == r_idx)) begin
                w_fill_nxt[k] = I_data;
            end
`ifdef MANTLE_FRAME_LAST_CHECK_EN
            else if (w_accept && I_last && (IW'(k) > r_idx)) begin
                w_fill_nxt[k] = '0;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_idx     <= '0;
            r_ovalid  <= 1'b0;
            r_pending <= 1'b0;
            r_count   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_fill[k] <= '0;
                r_out[k]  <= '0;
            end
        end else begin
            r_fill <= w_fill_nxt;
            if (w_accept) begin
                r_idx <= w_complete ? '0 : r_idx + IW'(1);
            end
            // A pending frame implies O_valid is already high, so draining keeps it high.
            if (r_pending && O_ready) begin
                r_out     <= r_fill;
                r_pending <= 1'b0;
            end else if (w_complete && w_out_free) begin
                r_out    <= w_fill_nxt;
                r_ovalid <= 1'b1;
            end else if (w_complete) begin
                r_pending <= 1'b1;
            end else if (w_handoff) begin
                r_ovalid <= 1'b0;
            end
            if (w_handoff) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

`ifdef MANTLE_FRAME_LAST_CHECK_EN
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_err <= 1'b0;
        end else if (w_accept && (I_last != w_at_last)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign O           = r_out;
    assign O_valid     = r_ovalid;
    assign frame_count = r_count;

endmodule

// File: tb/tb_mantle_frame_collector.sv
// Directed bench for mantle_frame_collector: vector table plus hand-written corner sequences.
// Define MANTLE_FRAME_LAST_CHECK_EN to also exercise I_last / err.
module tb_mantle_frame_collector;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN;
    logic [31:0] I_data;
    logic        I_valid;
    logic        I_ready;
    logic [31:0] O [8:0];
    logic        O_valid;
    logic        O_ready;
    logic [15:0] frame_count;
`ifdef MANTLE_FRAME_LAST_CHECK_EN
    logic        I_last;
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mantle_frame_collector #(.WIDTH(32), .DEPTH(9)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I_data     (I_data),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
`ifdef MANTLE_FRAME_LAST_CHECK_EN
        .I_last     (I_last),
        .err        (err),
`endif
        .O          (O),
        .O_valid    (O_valid),
        .O_ready    (O_ready),
        .frame_count(frame_count)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_o0;
        logic [31:0] e_o8;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
        I_valid = v;
        I_data  = d;
        O_ready = ordy;
    endtask

    // Cycle timing: inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed_frame(input logic [31:0] base, input logic ordy);
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, base + 32'(k), ordy);
`ifdef MANTLE_FRAME_LAST_CHECK_EN
            I_last = (k == 8);
`endif
            tick();
        end
        I_valid = 1'b0;
`ifdef MANTLE_FRAME_LAST_CHECK_EN
        I_last = 1'b0;
`endif
    endtask

    task automatic reset_mid_cycle();
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        check("rst_async_ovalid", 32'(O_valid), 32'd0);
        check("rst_async_iready", 32'(I_ready), 32'd1);
        check("rst_async_count", 32'(frame_count), 32'd0);
        tick();
        ASYNCRESETN = 1'b1;
    endtask

    logic [31:0] snap [8:0];
    logic [31:0] exp_q [$];
    logic        acc, hand, stall, ok;
    int          sent, frames;

    initial begin
        // Vector table: basic frame, backpressure into pending, drain.
        for (int k = 0; k < 9; k++)
            vecs[k] = '{1'b1, 32'(k), 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h8, 16'd0};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd1};
        for (int k = 0; k < 9; k++)
            vecs[11 + k] = '{1'b1, 32'h200 + 32'(k), 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd1};
        for (int k = 0; k < 9; k++)
            vecs[20 + k] = '{1'b1, 32'h210 + 32'(k), 1'b0, 1'b1, 1'b1, 32'h200, 32'h208, 16'd1};
        vecs[29] = '{1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1, 32'h200, 32'h208, 16'd1};
        vecs[30] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h208, 16'd1};
        vecs[31] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h210, 32'h218, 16'd2};
        vecs[32] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h210, 32'h218, 16'd2};
        vecs[33] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd3};

        drive(1'b0, 32'h0, 1'b0);
`ifdef MANTLE_FRAME_LAST_CHECK_EN
        I_last = 1'b0;
`endif
        ASYNCRESETN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ovalid", 32'(O_valid), 32'd0);
        check("reset_iready", 32'(I_ready), 32'd1);
        check("reset_count", 32'(frame_count), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 9; k++) if (O[k] !== 32'h0) ok = 1'b0;
        check("reset_O_zero", 32'(ok), 32'd1);
        ASYNCRESETN = 1'b1;

        for (int i = 0; i < 34; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_iready", i), 32'(I_ready), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_ovalid", i), 32'(O_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_count", i), 32'(frame_count), 32'(vecs[i].e_cnt));
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_O0", i), O[0], vecs[i].e_o0);
                check($sformatf("vec%0d_O8", i), O[8], vecs[i].e_o8);
            end
            if (i == 9) begin
                ok = 1'b1;
                for (int k = 0; k < 9; k++) if (O[k] !== 32'(k)) ok = 1'b0;
                check("frame1_all_elems", 32'(ok), 32'd1);
            end
            @(posedge CLK);
            #0;
            #1;
        end

        // Continuous stream with O_ready high: a frame every 9 cycles, I_ready never drops.
        for (int n = 0; n < 27; n++) begin
            drive(1'b1, 32'h100 + 32'(n), 1'b1);
            #1;
            check("stream_iready", 32'(I_ready), 32'd1);
            tick();
            if (n % 9 == 8) begin
                check("stream_ovalid", 32'(O_valid), 32'd1);
                check("stream_O0", O[0], 32'h100 + 32'(n - 8));
                check("stream_O8", O[8], 32'h100 + 32'(n));
            end else begin
                check("stream_ovalid_low", 32'(O_valid), 32'd0);
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        check("stream_count", 32'(frame_count), 32'd6);

        // Random gaps and backpressure against an in-order scoreboard.
        reset_mid_cycle();
        sent   = 0;
        frames = 0;
        for (int cyc = 0; cyc < 3000 && frames < 5; cyc++) begin
            drive((sent < 45) && ($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 1) == 1);
            #1;
            acc   = I_valid && I_ready;
            hand  = O_valid && O_ready;
            stall = O_valid && !O_ready;
            snap  = O;
            if (acc) begin
                exp_q.push_back(I_data);
                sent++;
            end
            if (hand) begin
                ok = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    if (exp_q.size() == 0 || O[k] !== exp_q[0]) ok = 1'b0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                check("rand_frame", 32'(ok), 32'd1);
                frames++;
            end
            tick();
            if (stall) begin
                ok = O_valid;
                for (int k = 0; k < 9; k++) if (O[k] !== snap[k]) ok = 1'b0;
                check("rand_stable", 32'(ok), 32'd1);
            end
        end
        check("rand_frames_done", 32'(frames), 32'd5);
        I_valid = 1'b0;

        // Reset with a partial frame (idx=4), then a clean frame.
        reset_mid_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h777 + 32'(k), 1'b1);
            tick();
        end
        I_valid = 1'b0;
        reset_mid_cycle();
        feed_frame(32'h300, 1'b1);
        check("post_rst1_ovalid", 32'(O_valid), 32'd1);
        for (int k = 0; k < 9; k++) check($sformatf("post_rst1_O%0d", k), O[k], 32'h300 + 32'(k));

        // Reset with a pending frame, then a clean frame.
        feed_frame(32'h380, 1'b0);
        check("pend_iready", 32'(I_ready), 32'd0);
        reset_mid_cycle();
        feed_frame(32'h400, 1'b1);
        check("post_rst2_ovalid", 32'(O_valid), 32'd1);
        check("post_rst2_count", 32'(frame_count), 32'd0);
        for (int k = 0; k < 9; k++) check($sformatf("post_rst2_O%0d", k), O[k], 32'h400 + 32'(k));

`ifdef MANTLE_FRAME_LAST_CHECK_EN
        reset_mid_cycle();
        feed_frame(32'h500, 1'b1);
        check("last_ok_err", 32'(err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'(k), 1'b1);
            I_last = (k == 5);
            tick();
        end
        I_valid = 1'b0;
        I_last  = 1'b0;
        check("early_last_ovalid", 32'(O_valid), 32'd1);
        check("early_last_O5", O[5], 32'h5);
        for (int k = 6; k < 9; k++) check($sformatf("early_last_O%0d", k), O[k], 32'h0);
        check("early_last_err", 32'(err), 32'd1);
        feed_frame(32'h600, 1'b1);
        check("after_good_O0", O[0], 32'h600);
        check("err_sticky", 32'(err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mantle_frame_collector.md
Name: mantle_frame_collector

Overview:
- Upstream neighbour of the mantle slice stage.
- Deserialises a valid/ready stream of WIDTH-bit words into one DEPTH-element array frame, O[DEPTH-1:0].
- Holds that frame stable until downstream accepts it; the slice stage then reads fixed element ranges combinationally.
- Double-buffered (fill buffer plus output register), so a full-rate stream sustains one frame per DEPTH cycles.

Parameters:
- WIDTH, 32, bits per array element
- DEPTH, 9, elements per frame (>=2)

Ports:
- CLK  input  1  clock, all state on rising edge
- ASYNCRESETN  input  1  asynchronous active-low reset
- I_data  input  WIDTH  stream word
- I_valid  input  1  I_data valid
- I_ready  output  1  collector accepts word this cycle
- O  output  [WIDTH-1:0] x [DEPTH-1:0] (unpacked array)  assembled frame, element k = k-th accepted word
- O_valid  output  1  O holds a complete frame
- O_ready  input  1  downstream consumes frame
- frame_count  output  16  number of frames handed off (O_valid & O_ready)

Behaviour:
- Interface: one clock (CLK); reset ASYNCRESETN is asynchronous and active-low.
- Reset values: fill index idx=0, pending=0, O_valid=0, O all zero, fill buffer zero, frame_count=0, I_ready=1 (combinational from pending).
- Word accept: I_valid & I_ready at an edge writes I_data to fill[idx]; idx increments.
- Frame completion: accepting the word at idx==DEPTH-1 completes the frame; idx wraps to 0 on the same edge.
- Transfer on completion, output free (O_valid==0, or O_valid & O_ready this cycle):
  - Output register loads fill[0..DEPTH-2] plus I_data into O[DEPTH-1] on the same edge.
  - O_valid=1 from the next cycle.
  - Latency: last word to O_valid is 1 cycle.
- Transfer on completion, output busy (O_valid & !O_ready):
  - Fill buffer keeps the complete frame; pending=1.
  - I_ready=0 while pending.
- Pending drain: at the first edge where O_ready=1, O loads the fill buffer, O_valid stays 1, pending clears. I_ready returns to 1 the following cycle; there is no combinational path from O_ready to I_ready.
- Handoff with nothing completing: O_valid & O_ready with no frame completing and no pending clears O_valid at that edge; O is not cleared (keeps last frame).
- Stability: O and O_valid are stable while O_valid & !O_ready.
- Throughput: with O_ready tied high and I_valid continuous, I_ready never drops; a new frame appears every DEPTH cycles.
- frame_count: increments on each O_valid & O_ready edge; wraps 0xFFFF->0x0000.
- Partial frames: idle I_valid mid-frame holds idx; there is no timeout.
- Reset mid-frame: asynchronously discards partial and pending frames, clears O_valid immediately.

Optional Feature:
- Macro: MANTLE_FRAME_LAST_CHECK_EN.
- Defined: adds ports I_last (input 1, frame end marker) and err (output 1, sticky, reset 0).
  - Expected: I_last=1 exactly on the word at idx==DEPTH-1.
  - Early I_last (idx<DEPTH-1): frame completes at that word; elements idx+1..DEPTH-1 are zero-filled; err set.
  - Missing I_last at idx==DEPTH-1: frame completes normally; err set.
  - err clears only on reset.
- Undefined: no I_last or err ports; frames delimited purely by count.

Test Plan:
- Reset, then feed words 0..8 back-to-back with O_ready=1 -> O_valid high 1 cycle after word 8; O[k]=k for k=0..8; frame_count=1; I_ready never low.
- 27 continuous words 0x100+n with O_ready=1 -> three frames at cycles 9/18/27; frame 2 O[0]=0x109; frame_count=3.
- Hold O_ready=0 after frame 1, stream 9 more words -> I_ready drops after word 17; O keeps frame 1. Raise O_ready -> O=frame 2 next cycle; I_ready=1 the cycle after.
- Random I_valid gaps (~50%) with random O_ready -> scoreboard frames match the input sequence in order; O never changes while O_valid & !O_ready.
- Assert ASYNCRESETN low mid-frame (idx=4) and mid-pending -> O_valid=0 and I_ready=1 immediately; next 9 words form a clean frame from O[0].
- MANTLE_FRAME_LAST_CHECK_EN: I_last on word 5 -> O[6..8]=0, err=1; subsequent well-formed frame leaves err=1.
